// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: Diff = A - B - Bin, one bit per clock, LSB first.
// A single full-subtractor cell is reused across WIDTH cycles behind a start/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             bor_q, bor_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic a_bit, b_bit, d_bit, bor_next;

    // Full-subtractor cell on the current LSBs and the running borrow.
    assign a_bit    = a_sh_q[0];
    assign b_bit    = b_sh_q[0];
    assign d_bit    = a_bit ^ b_bit ^ bor_q;
    assign bor_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bor_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            bor_q   <= 1'b0;
            cnt_q   <= '0;
            work_q  <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            bor_q   <= bor_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        bor_d   = bor_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        diff_d  = diff_q;
        bout_d  = bout_q;

        unique case (state_q)
            IDLE, DONE: begin
                // The edge leaving DONE may accept a new request so back-to-back
                // operations complete every WIDTH+1 cycles.
                if (start) begin
                    a_sh_d  = A;
                    b_sh_d  = B;
                    bor_d   = Bin;
                    cnt_d   = '0;
                    work_d  = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                work_d = {d_bit, work_q[WIDTH-1:1]};
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                bor_d  = bor_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    diff_d  = {d_bit, work_q[WIDTH-1:1]};
                    bout_d  = bor_next;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign Diff = diff_q;
    assign Bout = bout_q;
endmodule
